// File: rtl/sar_tx_pkg.sv
// sar_result_uart_tx shared types, frame constants and width helpers.
// Optional parity build: define SAR_TX_PARITY_EN.
package sar_tx_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_t;

   localparam int FRAME_BITS = 8;
   localparam int IDX_W      = $clog2(FRAME_BITS);

   function automatic int cnt_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   function automatic int lvl_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/sar_result_uart_tx_if.sv
// Result handshake between the SAR conversion FSM and the UART sender.
// master = SAR FSM side, slave = UART sender side.
interface sar_result_uart_tx_if #(
   parameter int DATA_W = 8
);
   logic [DATA_W-1:0] res_data;
   logic              res_valid;
   logic              res_ready;

   modport master (
      output res_data,
      output res_valid,
      input  res_ready
   );

   modport slave (
      input  res_data,
      input  res_valid,
      output res_ready
   );
endinterface

// File: rtl/sar_tx_fifo.sv
// Small synchronous FIFO; full/empty come from the occupancy count.
// Read data is shown combinationally from the head entry.
module sar_tx_fifo
   import sar_tx_pkg::*;
#(
   parameter  int WIDTH = 8,
   parameter  int DEPTH = 4,
   localparam int AW    = cnt_w(DEPTH),
   localparam int LW    = lvl_w(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty,
   output logic [LW-1:0]    level
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (level == LW'(DEPTH));
   assign empty   = (level == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rd_ptr];

   // Pointers wrap naturally (power-of-two depth); count tracks occupancy.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   level <= level + LW'(1);
            2'b01:   level <= level - LW'(1);
            default: level <= level;
         endcase
      end
   end

   // Storage array; contents are don't-care until written.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/sar_result_uart_tx.sv
// Buffers SAR results and sends each as an 8N1 UART frame on tx.
// Define SAR_TX_PARITY_EN for 8E1 frames (even parity bit before stop).
module sar_result_uart_tx
   import sar_tx_pkg::*;
#(
   parameter  int DATA_W       = 8,
   parameter  int CLKS_PER_BIT = 87,
   parameter  int FIFO_DEPTH   = 4,
   localparam int LVL_W        = lvl_w(FIFO_DEPTH)
) (
   input  logic                clk,
   input  logic                rst,
   sar_result_uart_tx_if.slave res,
   output logic                tx,
   output logic                busy,
   output logic                frame_done,
   output logic [LVL_W-1:0]    fifo_level
);

   localparam int CW = cnt_w(CLKS_PER_BIT);

   state_t                  state_q, state_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [FRAME_BITS-1:0]   sh_q, sh_d;
   logic                    tx_d;
   logic                    pop;
   logic                    full;
   logic                    empty;
   logic                    baud_end;
   logic [DATA_W-1:0]       rdata;
   logic [FRAME_BITS-1:0]   head;
`ifdef SAR_TX_PARITY_EN
   logic                    par_q, par_d;
`endif

   sar_tx_fifo #(
      .WIDTH (DATA_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (res.res_valid),
      .pop   (pop),
      .wdata (res.res_data),
      .rdata (rdata),
      .full  (full),
      .empty (empty),
      .level (fifo_level)
   );

   assign res.res_ready = !full;
   assign head          = FRAME_BITS'(rdata);
   assign baud_end      = (cnt_q == CW'(CLKS_PER_BIT - 1));
   assign frame_done    = (state_q == STOP) && baud_end;
   assign busy          = (state_q != IDLE) || (fifo_level != '0);

   // State, baud counter, shift register and the tx flop.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         sh_q    <= '0;
         tx      <= 1'b1;
`ifdef SAR_TX_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         sh_q    <= sh_d;
         tx      <= tx_d;
`ifdef SAR_TX_PARITY_EN
         par_q   <= par_d;
`endif
      end
   end

   // Next-state logic; every transition lands on a baud wrap, so the
   // counter restarts at zero on each state entry.
   always_comb begin
      state_d = state_q;
      cnt_d   = baud_end ? '0 : cnt_q + CW'(1);
      idx_d   = idx_q;
      sh_d    = sh_q;
      tx_d    = tx;
      pop     = 1'b0;
`ifdef SAR_TX_PARITY_EN
      par_d   = par_q;
`endif
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            tx_d  = 1'b1;
            if (!empty) begin
               pop     = 1'b1;
               sh_d    = head;
               tx_d    = 1'b0;
               state_d = START;
`ifdef SAR_TX_PARITY_EN
               par_d   = ^head;
`endif
            end
         end
         START: begin
            if (baud_end) begin
               idx_d   = '0;
               tx_d    = sh_q[0];
               state_d = DATA;
            end
         end
         DATA: begin
            if (baud_end) begin
               if (idx_q == IDX_W'(FRAME_BITS - 1)) begin
`ifdef SAR_TX_PARITY_EN
                  tx_d    = par_q;
                  state_d = PARITY;
`else
                  tx_d    = 1'b1;
                  state_d = STOP;
`endif
               end else begin
                  idx_d = idx_q + IDX_W'(1);
                  sh_d  = sh_q >> 1;
                  tx_d  = sh_q[1];
               end
            end
         end
`ifdef SAR_TX_PARITY_EN
         PARITY: begin
            if (baud_end) begin
               tx_d    = 1'b1;
               state_d = STOP;
            end
         end
`endif
         STOP: begin
            if (baud_end) begin
               if (!empty) begin
                  pop     = 1'b1;
                  sh_d    = head;
                  tx_d    = 1'b0;
                  state_d = START;
`ifdef SAR_TX_PARITY_EN
                  par_d   = ^head;
`endif
               end else begin
                  tx_d    = 1'b1;
                  state_d = IDLE;
               end
            end
         end
         default: begin
            tx_d    = 1'b1;
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_sar_result_uart_tx.sv
// Directed bench for sar_result_uart_tx (CLKS_PER_BIT=4, depth 4, 8-bit).
// Build with SAR_TX_PARITY_EN to exercise the 8E1 frame.
module tb_sar_result_uart_tx;

   localparam int CPB = 4;
`ifdef SAR_TX_PARITY_EN
   localparam int FRAME_CYC = 11 * CPB;
`else
   localparam int FRAME_CYC = 10 * CPB;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       tx;
   logic       busy;
   logic       frame_done;
   logic [2:0] fifo_level;
   int         checks = 0;
   int         errors = 0;
   logic [2:0] lvl_peak = '0;

   sar_result_uart_tx_if #(.DATA_W(8)) res_if ();

   sar_result_uart_tx #(
      .DATA_W       (8),
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (4)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .res        (res_if),
      .tx         (tx),
      .busy       (busy),
      .frame_done (frame_done),
      .fifo_level (fifo_level)
   );

   always #5 clk = ~clk;

   // Track the highest occupancy seen.
   always @(negedge clk) begin
      if (fifo_level > lvl_peak) lvl_peak = fifo_level;
   end

   initial begin
      #400000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_fall(output int n);
      n = 0;
      do begin
         step();
         n++;
      end while (tx !== 1'b0 && n < 300);
      if (tx !== 1'b0) n = -1;
   endtask

   // Decode one frame; entered at frame cycle j0 (cycle 1 = first start cycle).
   task automatic rx_frame(input int j0, output logic [7:0] b,
                           output logic start_ok, output logic stop_ok,
                           output logic par, output int done_cnt,
                           output int done_at);
      b = '0;
      par = 1'b0;
      stop_ok = 1'b0;
      done_cnt = 0;
      done_at = -1;
      start_ok = (tx === 1'b0);
      for (int j = j0; j <= FRAME_CYC; j++) begin
         if (j > j0) step();
         for (int i = 0; i < 8; i++)
            if (j == 1 + CPB * (i + 1) + CPB / 2) b[i] = tx;
         if (j == 9 * CPB + 1 + CPB / 2) par = tx;
         if (j == FRAME_CYC - 1) stop_ok = (tx === 1'b1);
         if (frame_done === 1'b1) begin
            done_cnt++;
            done_at = j;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      res_if.res_valid = 1'b0;
      res_if.res_data = '0;
      step();
      step();
      checks++;
      if ({tx, res_if.res_ready, busy, frame_done, fifo_level} !== 7'b1100000) begin
         errors++;
         $display("FAIL reset_state: tx/ready/busy/done/level=%b required 1100000",
                  {tx, res_if.res_ready, busy, frame_done, fifo_level});
      end
      rst = 1'b0;
      for (int c = 0; c < 20; c++) begin
         step();
         checks++;
         if ({tx, res_if.res_ready, busy, frame_done, fifo_level} !== 7'b1100000) begin
            errors++;
            $display("FAIL idle_cycle%0d: tx/ready/busy/done/level=%b required 1100000",
                     c, {tx, res_if.res_ready, busy, frame_done, fifo_level});
         end
      end
   endtask

   task automatic test_single();
      logic [7:0] v;
      logic       exp;
      v = 8'hA5;
      res_if.res_data = v;
      res_if.res_valid = 1'b1;
      step();
      res_if.res_valid = 1'b0;
      checks++;
      if (fifo_level !== 3'd1 || tx !== 1'b1 || busy !== 1'b1) begin
         errors++;
         $display("FAIL single_push: level=%0d tx=%b busy=%b required 1 1 1",
                  fifo_level, tx, busy);
      end
      for (int j = 1; j <= 40; j++) begin
         step();
         if (j <= CPB) exp = 1'b0;
         else if (j <= 9 * CPB) exp = v[(j - CPB - 1) / CPB];
         else exp = 1'b1;
         checks++;
         if (tx !== exp || frame_done !== (j == 40)) begin
            errors++;
            $display("FAIL single_cycle%0d: tx=%b done=%b required tx=%b done=%b",
                     j, tx, frame_done, exp, (j == 40));
         end
      end
      step();
      checks++;
      if (busy !== 1'b0 || tx !== 1'b1) begin
         errors++;
         $display("FAIL single_after: busy=%b tx=%b required 0 1", busy, tx);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] w [3];
      logic [7:0] b;
      logic       s_ok, p_ok, par;
      int         dc, da, gap;
      w[0] = 8'h01;
      w[1] = 8'h80;
      w[2] = 8'hFF;
      lvl_peak = '0;
      res_if.res_valid = 1'b1;
      res_if.res_data = w[0];
      step();
      res_if.res_data = w[1];
      step();
      res_if.res_data = w[2];
      step();
      res_if.res_valid = 1'b0;
      for (int f = 0; f < 3; f++) begin
         if (f == 0) begin
            rx_frame(2, b, s_ok, p_ok, par, dc, da);
         end else begin
            wait_fall(gap);
            checks++;
            if (gap != 1) begin
               errors++;
               $display("FAIL b2b_gap%0d: cycles to start=%0d required 1", f, gap);
            end
            rx_frame(1, b, s_ok, p_ok, par, dc, da);
         end
         checks++;
         if (b !== w[f] || !s_ok || !p_ok || dc != 1 || da != FRAME_CYC) begin
            errors++;
            $display("FAIL b2b_frame%0d: byte=%h start=%b stop=%b done=%0d@%0d required %h 1 1 1@%0d",
                     f, b, s_ok, p_ok, dc, da, w[f], FRAME_CYC);
         end
      end
      checks++;
      if (lvl_peak !== 3'd2) begin
         errors++;
         $display("FAIL b2b_peak: level peak=%0d required 2", lvl_peak);
      end
      step();
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL b2b_busy: busy=%b required 0", busy);
      end
   endtask

   task automatic test_fill();
      logic [7:0] w [6];
      logic [7:0] got [6];
      logic       saw_low;
      w = '{8'h11, 8'h22, 8'h3C, 8'h4B, 8'h5A, 8'h69};
      saw_low = 1'b0;
      fork
         begin
            int n;
            logic acc;
            n = 0;
            for (int it = 0; it < 400 && n < 6; it++) begin
               res_if.res_data = w[n];
               res_if.res_valid = 1'b1;
               acc = res_if.res_ready;
               if (!acc) begin
                  saw_low = 1'b1;
                  checks++;
                  if (fifo_level !== 3'd4) begin
                     errors++;
                     $display("FAIL fill_ready_low: level=%0d required 4", fifo_level);
                  end
               end
               step();
               if (acc) n++;
            end
            res_if.res_valid = 1'b0;
            checks++;
            if (n != 6) begin
               errors++;
               $display("FAIL fill_pushes: accepted=%0d required 6", n);
            end
         end
         begin
            logic [7:0] b;
            logic       s_ok, p_ok, par;
            int         dc, da, g;
            for (int f = 0; f < 6; f++) begin
               wait_fall(g);
               if (g < 0) begin
                  got[f] = 8'hXX;
               end else begin
                  rx_frame(1, b, s_ok, p_ok, par, dc, da);
                  got[f] = b;
               end
            end
         end
      join
      for (int f = 0; f < 6; f++) begin
         checks++;
         if (got[f] !== w[f]) begin
            errors++;
            $display("FAIL fill_byte%0d: got=%h required %h", f, got[f], w[f]);
         end
      end
      checks++;
      if (saw_low !== 1'b1) begin
         errors++;
         $display("FAIL fill_backpressure: ready low seen=%b required 1", saw_low);
      end
      step();
      checks++;
      if (busy !== 1'b0 || fifo_level !== 3'd0) begin
         errors++;
         $display("FAIL fill_drain: busy=%b level=%0d required 0 0", busy, fifo_level);
      end
   endtask

   task automatic test_reset_mid();
      logic bad;
      res_if.res_valid = 1'b1;
      res_if.res_data = 8'hC3;
      step();
      res_if.res_data = 8'h5A;
      step();
      res_if.res_data = 8'h0F;
      step();
      res_if.res_valid = 1'b0;
      for (int j = 3; j <= 18; j++) step();
      checks++;
      if (fifo_level !== 3'd2) begin
         errors++;
         $display("FAIL rstmid_queued: level=%0d required 2", fifo_level);
      end
      rst = 1'b1;
      step();
      checks++;
      if ({tx, res_if.res_ready, busy, frame_done, fifo_level} !== 7'b1100000) begin
         errors++;
         $display("FAIL rstmid_state: tx/ready/busy/done/level=%b required 1100000",
                  {tx, res_if.res_ready, busy, frame_done, fifo_level});
      end
      rst = 1'b0;
      bad = 1'b0;
      for (int c = 0; c < 100; c++) begin
         step();
         if (tx !== 1'b1 || frame_done !== 1'b0 || busy !== 1'b0) bad = 1'b1;
      end
      checks++;
      if (bad) begin
         errors++;
         $display("FAIL rstmid_quiet: activity after reset=%b required 0", bad);
      end
   endtask

`ifdef SAR_TX_PARITY_EN
   task automatic test_parity();
      logic [7:0] v [2];
      logic       ep [2];
      logic [7:0] b;
      logic       s_ok, p_ok, par;
      int         dc, da, g;
      v[0] = 8'h07;
      ep[0] = 1'b1;
      v[1] = 8'h03;
      ep[1] = 1'b0;
      for (int f = 0; f < 2; f++) begin
         res_if.res_data = v[f];
         res_if.res_valid = 1'b1;
         step();
         res_if.res_valid = 1'b0;
         wait_fall(g);
         rx_frame(1, b, s_ok, p_ok, par, dc, da);
         checks++;
         if (b !== v[f] || par !== ep[f] || !p_ok || dc != 1 || da != 44) begin
            errors++;
            $display("FAIL parity_frame%0d: byte=%h par=%b stop=%b done=%0d@%0d required %h %b 1 1@44",
                     f, b, par, p_ok, dc, da, v[f], ep[f]);
         end
         step();
         step();
      end
   endtask
`endif

   initial begin
      res_if.res_valid = 1'b0;
      res_if.res_data = '0;
      test_reset();
      test_single();
      step();
      test_back_to_back();
      step();
      test_fill();
      step();
      test_reset_mid();
`ifdef SAR_TX_PARITY_EN
      test_parity();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sar_result_uart_tx.md
Name: sar_result_uart_tx

Overview:
Downstream consumer of the SAR conversion FSM inside tt_um_fsm_sar_bs. It accepts each finished conversion result on a valid/ready handshake and buffers it in a small FIFO. It then serialises the result as an 8N1 UART frame on a dedicated output pin, so an off-chip host can log ADC samples without polling the parallel uo_out bus.

Parameters:
- DATA_W, 8, conversion result width. Legal range 1..8. Zero-extended to 8 frame bits.
- CLKS_PER_BIT, 87, clock cycles per UART bit. 10 MHz / 115200 baud. Legal value ≥ 2.
- FIFO_DEPTH, 4, result buffer entries. Power of two, ≥ 2.

Ports:
- clk  in  1  system clock, single domain.
- rst  in  1  synchronous, active-high reset. Top level drives rst = ~rst_n.
- res_data  in  DATA_W  SAR result, LSB = final binary-search bit.
- res_valid  in  1  result valid from SAR FSM.
- res_ready  out  1  FIFO can accept. Equals !full (combinational from registered count).
- tx  out  1  UART serial line, idle high.
- busy  out  1  high while a frame is on the line or the FIFO is non-empty.
- frame_done  out  1  one-cycle pulse on the final cycle of each stop bit.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset values (on the first edge with rst=1, regardless of state): tx=1, res_ready=1, busy=0, frame_done=0, fifo_level=0. Any in-flight frame is aborted and the FIFO is emptied.
- Push occurs when res_valid && res_ready at a rising edge. If the FIFO is full, res_ready=0, nothing is written, and the SAR FSM must hold.
- FSM states:
  - IDLE: if the FIFO is non-empty, pop, load the shift register, go to START, tx<=0.
  - START: after CLKS_PER_BIT cycles, go to DATA, bit_idx=0.
  - DATA: 8 bits, LSB first, each CLKS_PER_BIT cycles. After bit 7, go to STOP (or PARITY when enabled).
  - STOP: tx=1 for CLKS_PER_BIT cycles. frame_done is pulsed on the last cycle. Then, on that same edge: if the FIFO is non-empty, pop and go to START (no idle gap); otherwise go to IDLE.
- Latency: a push at edge k into an empty FIFO while in IDLE makes tx fall after edge k+1. Full frame length is 10*CLKS_PER_BIT cycles.
- tx is driven from a flop, with no combinational path from any input.
- Simultaneous push and pop in the same cycle: occupancy is unchanged and both operations take effect. Push when full is impossible because ready is low. Pop when empty never occurs.
- Baud counter counts 0..CLKS_PER_BIT-1 and wraps. It is reset to 0 on every state entry.
- FIFO read/write pointers wrap modulo FIFO_DEPTH. Full/empty are determined from the count, not from pointer equality.
- busy = (state != IDLE) || (fifo_level != 0).

Optional Feature:
- Macro: SAR_TX_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP. It transmits the even parity (XOR) of the 8 frame bits for CLKS_PER_BIT cycles, making the frame 8E1 with length 11*CLKS_PER_BIT.
- Undefined: no PARITY state exists, and the frame is 8N1 with length 10*CLKS_PER_BIT.

Decomposition:
- Package sar_tx_pkg holds:
  - state enum: IDLE, START, DATA, PARITY, STOP;
  - FRAME_BITS=8;
  - localparam helpers for counter widths.
- Sub-module sar_tx_fifo contains the synchronous FIFO with push/pop/full/empty/level, parameterised by width and depth. The top holds the FSM, baud counter and shift register.

Test Plan (CLKS_PER_BIT=4, FIFO_DEPTH=4, DATA_W=8):
- Reset, then idle 20 cycles -> tx=1, res_ready=1, busy=0, fifo_level=0 throughout.
- Push 0xA5 at edge k -> tx low during cycles k+1..k+4. Data bits 1,0,1,0,0,1,0,1 at 4 cycles each, then stop high. frame_done pulses at edge k+40. busy drops afterwards.
- Push 0x01, 0x80, 0xFF on consecutive cycles -> three frames back-to-back with no idle cycle between a stop bit and the next start bit. Decoded bytes arrive in order, and fifo_level peaks at 2.
- Push 6 words while res_valid is held high -> res_ready goes low once occupancy reaches 4. No word is lost or duplicated, and all 6 bytes are decoded in order.
- Assert rst during bit 3 of a frame with 2 words queued -> on the next cycle tx=1, fifo_level=0, busy=0. No further frame is emitted.
- With SAR_TX_PARITY_EN defined, push 0x07 -> parity bit=1, frame length 44 cycles. Push 0x03 -> parity bit=0.
